rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Board-level reset sequencer that owns every block reset in the design. It synchronizes the asynchronous `sys_rst_n` internally, then releases `NUM_DOMAINS` block resets one at a time with a fixed spacing, so that domain 0 comes out of reset first. After power-up it also performs a handshaked soft reset of domains 1..N-1 on request. Domain 0 is the always-on domain and is untouched by soft reset.

## Interface
- `NUM_DOMAINS`, 4: number of reset outputs; legal range 2..8.
- `STAGE_DLY`, 16: falling-clock edges between successive releases; minimum 1.
- `clk` input 1: system clock. All flops trigger on the falling edge.
- `sys_rst_n` input 1: reset, asynchronous, active-low.
- `soft_req` input 1: soft-reset request, level-held by the requester until `soft_ack`.
- `domain_rst_n` output `NUM_DOMAINS`: per-domain active-low reset; bit k is domain k.
- `seq_done` output 1: high while every domain is out of reset.
- `soft_ack` output 1: one-cycle pulse when a soft reset completes.

## Operation
- Reset values (`sys_rst_n` low): `domain_rst_n` = all zeros, `seq_done` = 0, `soft_ack` = 0, state = ST_SEQ, counter = 0, domain index = 0.
- Assertion of any `domain_rst_n` bit by `sys_rst_n` is asynchronous. Every release is synchronous.
- **ST_SEQ**
  - The stage counter counts falling edges.
  - When the counter reaches `STAGE_DLY`, the current domain index is released, the counter clears and the index increments.
  - When the last domain (`NUM_DOMAINS`-1) is released, `seq_done` goes to 1 and the FSM moves to ST_RUN on that same edge.
- **ST_RUN**
  - A rising edge of `soft_req` triggers a soft reset. Rising edge means sampled high at this edge and sampled low at the previous edge.
  - On the detecting edge: `domain_rst_n[NUM_DOMAINS-1:1]` go to 0, `seq_done` goes to 0, the counter clears, the index is set to 1 and the FSM returns to ST_SEQ. A soft-reset flag is set.
- When ST_SEQ completes with the soft-reset flag set, `soft_ack` pulses for one cycle and the flag clears.
- Requests and events outside ST_RUN:
  - `soft_req` edges outside ST_RUN are ignored. Requests are not queued.
  - A request held high through completion does not retrigger. Re-arming requires `soft_req` to be sampled low for at least one edge.
- `sys_rst_n` asserted at any point, including mid-sequence or mid-soft-reset, returns the block to reset values immediately. The full sequence restarts from domain 0 after release.
- Width rules:
  - Counter width is `$clog2(STAGE_DLY+1)`.
  - Index width is `$clog2(NUM_DOMAINS)`, with a minimum of 1.
  - The counter saturates; it never wraps.

## Timing
- **E0**: the first falling edge at which the internal synchronized reset reads 1. This is the 2nd falling edge after `sys_rst_n` deasserts.
- **Power-up release:** domain k is released at edge E0 + (k+1)·`STAGE_DLY`. `seq_done` rises at E0 + `NUM_DOMAINS`·`STAGE_DLY`.
- **Soft reset:** with F as the detecting edge, domains 1..N-1 fall at F.
  - Domain k (k≥1) is released at F + (k+1)·`STAGE_DLY`.
  - `seq_done` and `soft_ack` rise at F + `NUM_DOMAINS`·`STAGE_DLY`.
  - `soft_ack` falls one edge later.
- All outputs are registered. Downstream rising-edge logic sees changes half a cycle after the falling edge.

## Configuration
- Macro: `RST_SEQ_SOFT_EN`.
- **Defined:** soft reset works as described above.
- **Undefined:**
  - `soft_req` is unused.
  - `soft_ack` is tied to 0.
  - The edge detector and soft-reset flag are not built.
  - ST_RUN is terminal until `sys_rst_n` asserts.

## Structure
- Package `rst_seq_pkg` holds:
  - typedef enum `rst_seq_state_t` {ST_SEQ, ST_RUN};
  - the maximum `NUM_DOMAINS` limit constant.
- Sub-module `rst_seq_sync`:
  - two-flop falling-edge reset synchronizer;
  - async assert, sync release;
  - drives the FSM's internal reset.
- The FSM, counter, index, edge detector and output register live in `rst_seq_ctrl`.

## Test plan
All scenarios use `NUM_DOMAINS`=4 and `STAGE_DLY`=4.

- **Power-up release:** release `sys_rst_n`. Required: `domain_rst_n` = 0001 at E0+4, 0011 at E0+8, 0111 at E0+12, 1111 at E0+16, with `seq_done`=1 at E0+16.
- **Soft reset:** raise `soft_req` in ST_RUN, detected at F. Required:
  - `domain_rst_n` = 0001 at F, with bit 0 never low;
  - 0011 at F+8, 0111 at F+12, 1111 at F+16;
  - `soft_ack` high only for the F+16 cycle.
- **Ignored requests:** pulse `soft_req` during power-up sequencing. Hold `soft_req` high across completion. Required: no extra soft reset and no extra `soft_ack` in either case.
- **Async reset mid-sequence:** assert `sys_rst_n` asynchronously at E0+10. Required: `domain_rst_n`=0000 immediately, before the next clock edge; after release, the sequence restarts from domain 0.
- **Async reset mid-soft-reset:** assert `sys_rst_n` at F+6. Required: all outputs at reset values, and `soft_ack` never pulses.
- **Macro off:** build without `RST_SEQ_SOFT_EN` and toggle `soft_req` in ST_RUN. Required: `domain_rst_n` stays 1111 and `soft_ack` stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and limits for the board-level reset sequencer.
package rst_seq_pkg;

    localparam int MAX_DOMAINS = 8;

    typedef enum logic {
        ST_SEQ = 1'b0,
        ST_RUN = 1'b1
    } rst_seq_state_t;

    // Index register width: enough to address every domain, never narrower than one bit.
    function automatic int idx_width(input int num_domains);
        return (num_domains > 2) ? $clog2(num_domains) : 1;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop falling-edge reset synchronizer: asserts asynchronously, releases on the
// second falling edge after sys_rst_n deasserts.
module rst_seq_sync (
    input  logic clk,
    input  logic sys_rst_n,
    output logic sync_rst_n
);

    logic meta;

    // NOTE: flops use non-blocking assignments so both stages sample the same old
    // values on an edge; blocking here would collapse the chain to a single flop.
    always_ff @(negedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta       <= 1'b0;
            sync_rst_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            sync_rst_n <= meta;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases NUM_DOMAINS block resets one at a time, STAGE_DLY falling
// edges apart, and optionally (macro RST_SEQ_SOFT_EN) soft-resets domains 1..N-1.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_DLY   = 16
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   soft_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   seq_done,
    output logic                   soft_ack
);

    localparam int CNT_W = $clog2(STAGE_DLY + 1);
    localparam int IDX_W = idx_width(NUM_DOMAINS);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(STAGE_DLY);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS < 2 || NUM_DOMAINS > MAX_DOMAINS || STAGE_DLY < 1) begin : g_bad_param
        $error("rst_seq_ctrl: NUM_DOMAINS must be 2..%0d and STAGE_DLY at least 1", MAX_DOMAINS);
    end

    logic core_rst_n;

    rst_seq_sync u_sync (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .sync_rst_n (core_rst_n)
    );

    rst_seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   done_q, done_d;

    assign cnt_inc = (cnt_q == CNT_END) ? cnt_q : cnt_q + 1'b1;

`ifdef RST_SEQ_SOFT_EN
    logic req_q;
    logic flag_q, flag_d;
    logic lead_q, lead_d;
    logic ack_q, ack_d;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
`ifdef RST_SEQ_SOFT_EN
        flag_d  = flag_q;
        lead_d  = lead_q;
        ack_d   = 1'b0;
`endif
        case (state_q)
            ST_SEQ: begin
                if (cnt_inc == CNT_END) begin
                    cnt_d = '0;
`ifdef RST_SEQ_SOFT_EN
                    // A soft reset holds domains low for one extra stage before domain 1 leaves.
                    if (lead_q) begin
                        lead_d = 1'b0;
                    end else
`endif
                    begin
                        dom_d[idx_q] = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_RUN;
`ifdef RST_SEQ_SOFT_EN
                            ack_d   = flag_q;
                            flag_d  = 1'b0;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
`ifdef RST_SEQ_SOFT_EN
                if (soft_req && !req_q) begin
                    dom_d[NUM_DOMAINS-1:1] = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    idx_d   = IDX_W'(1);
                    state_d = ST_SEQ;
                    flag_d  = 1'b1;
                    lead_d  = 1'b1;
                end
`endif
            end
            default: state_d = ST_SEQ;
        endcase
    end

    always_ff @(negedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q <= ST_SEQ;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
        end
    end

`ifdef RST_SEQ_SOFT_EN
    always_ff @(negedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            req_q  <= 1'b0;
            flag_q <= 1'b0;
            lead_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            req_q  <= soft_req;
            flag_q <= flag_d;
            lead_q <= lead_d;
            ack_q  <= ack_d;
        end
    end

    assign soft_ack = ack_q;
`else
    logic unused_soft_req;
    assign unused_soft_req = soft_req;
    assign soft_ack        = 1'b0;
`endif

    assign domain_rst_n = dom_q;
    assign seq_done     = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (NUM_DOMAINS=4, STAGE_DLY=4); soft-reset scenarios
// run when RST_SEQ_SOFT_EN is defined, the macro-off scenario otherwise.
module tb_rst_seq_ctrl;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk;
    logic          sys_rst_n;
    logic          soft_req;
    logic [ND-1:0] domain_rst_n;
    logic          seq_done;
    logic          soft_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    rst_seq_ctrl #(
        .NUM_DOMAINS (ND),
        .STAGE_DLY   (SD)
    ) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .soft_req     (soft_req),
        .domain_rst_n (domain_rst_n),
        .seq_done     (seq_done),
        .soft_ack     (soft_ack)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Advance n falling edges, then sit on the following rising edge to sample.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        @(posedge clk);
    endtask

    // Called on a rising edge with sys_rst_n low; releases it and traces E0..E0+16.
    task automatic run_power_up(input string tag);
        logic [ND-1:0] exp_dom;
        sys_rst_n = 1'b1;
        step(2);
        tests_run++;
        if (domain_rst_n !== '0) begin
            tests_failed++;
            $display("FAIL %s_e0: domain_rst_n=%b expected %b", tag, domain_rst_n, 4'b0000);
        end
        for (int e = 1; e <= 4 * SD; e++) begin
            step(1);
            for (int k = 0; k < ND; k++) exp_dom[k] = (e >= (k + 1) * SD);
            tests_run++;
            if (domain_rst_n !== exp_dom) begin
                tests_failed++;
                $display("FAIL %s_dom e0+%0d: domain_rst_n=%b expected %b", tag, e, domain_rst_n, exp_dom);
            end
            tests_run++;
            if (seq_done !== (e == 4 * SD)) begin
                tests_failed++;
                $display("FAIL %s_done e0+%0d: seq_done=%b expected %b", tag, e, seq_done, (e == 4 * SD));
            end
            tests_run++;
            if (soft_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_ack e0+%0d: soft_ack=%b expected 0", tag, e, soft_ack);
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        soft_req  = 1'b0;
        step(3);
        tests_run++;
        if (domain_rst_n !== 4'b0000 || seq_done !== 1'b0 || soft_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: dom=%b done=%b ack=%b expected dom=0000 done=0 ack=0",
                     domain_rst_n, seq_done, soft_ack);
        end
    endtask

    task automatic test_power_up();
        run_power_up("power_up");
        step(3);
        tests_run++;
        if (domain_rst_n !== 4'b1111 || seq_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL power_up_hold: dom=%b done=%b expected dom=1111 done=1", domain_rst_n, seq_done);
        end
    endtask

    task automatic test_ignored_requests();
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        step(2);               // E0
        step(5);               // E0+5: short pulse during sequencing
        soft_req = 1'b1;
        step(2);
        soft_req = 1'b0;
        step(5);               // E0+12: raise and hold across completion
        soft_req = 1'b1;
        step(4);               // E0+16
        tests_run++;
        if (domain_rst_n !== 4'b1111 || seq_done !== 1'b1 || soft_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_complete: dom=%b done=%b ack=%b expected dom=1111 done=1 ack=0",
                     domain_rst_n, seq_done, soft_ack);
        end
        for (int e = 17; e <= 40; e++) begin
            step(1);
            tests_run++;
            if (domain_rst_n !== 4'b1111 || soft_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL ignored_held e0+%0d: dom=%b ack=%b expected dom=1111 ack=0",
                         e, domain_rst_n, soft_ack);
            end
        end
        soft_req = 1'b0;
        step(2);
    endtask

    task automatic test_async_mid_seq();
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        step(2);               // E0
        step(10);              // E0+10
        tests_run++;
        if (domain_rst_n !== 4'b0011) begin
            tests_failed++;
            $display("FAIL mid_seq_pre: domain_rst_n=%b expected 0011", domain_rst_n);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if (domain_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_seq_async: dom=%b done=%b expected dom=0000 done=0", domain_rst_n, seq_done);
        end
        step(2);
        run_power_up("restart");
    endtask

`ifdef RST_SEQ_SOFT_EN
    task automatic test_soft_reset();
        logic [ND-1:0] exp_dom;
        soft_req = 1'b1;
        step(1);               // F
        tests_run++;
        if (domain_rst_n !== 4'b0001 || seq_done !== 1'b0 || soft_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL soft_f: dom=%b done=%b ack=%b expected dom=0001 done=0 ack=0",
                     domain_rst_n, seq_done, soft_ack);
        end
        for (int e = 1; e <= 4 * SD; e++) begin
            step(1);
            exp_dom[0] = 1'b1;
            for (int k = 1; k < ND; k++) exp_dom[k] = (e >= (k + 1) * SD);
            tests_run++;
            if (domain_rst_n !== exp_dom) begin
                tests_failed++;
                $display("FAIL soft_dom f+%0d: domain_rst_n=%b expected %b", e, domain_rst_n, exp_dom);
            end
            tests_run++;
            if (seq_done !== (e == 4 * SD) || soft_ack !== (e == 4 * SD)) begin
                tests_failed++;
                $display("FAIL soft_done_ack f+%0d: done=%b ack=%b expected %b", e, seq_done, soft_ack, (e == 4 * SD));
            end
        end
        soft_req = 1'b0;
        step(1);               // F+17
        tests_run++;
        if (soft_ack !== 1'b0 || seq_done !== 1'b1 || domain_rst_n !== 4'b1111) begin
            tests_failed++;
            $display("FAIL soft_ack_fall: ack=%b done=%b dom=%b expected ack=0 done=1 dom=1111",
                     soft_ack, seq_done, domain_rst_n);
        end
        step(2);
    endtask

    task automatic test_async_mid_soft();
        soft_req = 1'b1;
        step(1);               // F
        tests_run++;
        if (domain_rst_n !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_soft_f: domain_rst_n=%b expected 0001", domain_rst_n);
        end
        step(6);               // F+6
        #2 sys_rst_n = 1'b0;
        soft_req = 1'b0;
        #1;
        tests_run++;
        if (domain_rst_n !== 4'b0000 || seq_done !== 1'b0 || soft_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_soft_async: dom=%b done=%b ack=%b expected dom=0000 done=0 ack=0",
                     domain_rst_n, seq_done, soft_ack);
        end
        step(2);
        run_power_up("after_soft");
    endtask
`else
    task automatic test_macro_off();
        for (int i = 0; i < 6; i++) begin
            soft_req = ~soft_req;
            step(2);
            tests_run++;
            if (domain_rst_n !== 4'b1111 || soft_ack !== 1'b0 || seq_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL macro_off %0d: dom=%b ack=%b done=%b expected dom=1111 ack=0 done=1",
                         i, domain_rst_n, soft_ack, seq_done);
            end
        end
        soft_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_ignored_requests();
        test_async_mid_seq();
`ifdef RST_SEQ_SOFT_EN
        test_soft_reset();
        test_async_mid_soft();
`else
        test_macro_off();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
